// File: rtl/hex_page_scheduler.sv
// rtl/hex_page_scheduler.sv - round-robin time-sharing of the hex display between page requesters
module hex_page_scheduler #(
  parameter int NREQ   = 4,
  parameter int DIGITS = 6,
  parameter int DWELL  = 50_000_000
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DIGITS*4-1:0] page,
  input  logic                     hold,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          active,
  output logic                     busy,
  output logic [DIGITS*4-1:0]      Digits
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   last;
  logic [LW-1:0]   win;
  logic            found;
  logic            grant;

  // Search starts just after the last grant and ends on it, so a lone requester re-wins.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last) + k) % NREQ]) begin
        win   = LW'((int'(last) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  assign grant = !hold && (req != '0) && ((state == IDLE) || (cnt == '0));
  assign busy  = (state == SHOW);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= LW'(NREQ - 1);
      Digits <= '0;
      ack    <= '0;
      active <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        Digits <= page[int'(win)*DIGITS*4 +: DIGITS*4];
        ack    <= ONE << win;
        active <= ONE << win;
        last   <= win;
        cnt    <= CW'(DWELL - 1);
        state  <= SHOW;
      end else if (state == SHOW && !hold) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state  <= IDLE;
          active <= '0;
        end
      end
    end
  end

endmodule
